// File: rtl/bram_model_pkg.sv
// bram_model_pkg
// Shared types and default parameter values for the bram_model block.
//   - *_DEFAULT : default values for the bram_model parameters
//   - rsp_e : kind of response carried down the latency pipeline
//   - pipe_entry_t : one pipeline slot (response kind + data word)
// The data field is sized for the widest legal word (64 bits). Narrower
// configurations zero-extend into it and truncate on the way out.
package bram_model_pkg;

  localparam int          DATA_W_DEFAULT       = 32;
  localparam int          DEPTH_DEFAULT        = 256;
  localparam logic [31:0] BASE_ADDR_DEFAULT    = 32'hB000_0000;
  localparam int          READ_LATENCY_DEFAULT = 1;
  localparam int          DATA_W_MAX           = 64;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_DATA = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_e;

  typedef struct packed {
    rsp_e                  rsp;
    logic [DATA_W_MAX-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/bram_model_if.sv
// bram_model_if
// Request/response bus of the bram_model block.
//   en, we, addr, wdata, be : request side (driven by the master)
//   rdata, rvalid, err      : response side (driven by the memory)
interface bram_model_if #(
  parameter int DATA_W = 32
);

  logic                  en;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output en, we, addr, wdata, be,
    input  rdata, rvalid, err
  );

  modport slave (
    input  en, we, addr, wdata, be,
    output rdata, rvalid, err
  );

endinterface

// File: rtl/bram_model_pipe.sv
// bram_model_pipe
// Fixed-latency response delay line. An entry presented on in_entry in the
// cycle a request is accepted appears on the registered outputs exactly
// READ_LATENCY cycles later. reset_n low flushes every in-flight entry at
// once and forces the outputs to their idle values.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   in_entry     : response generated for the request accepted this cycle
//   rdata        : response data, held between responses
//   rvalid, err  : one-cycle response pulses
module bram_model_pipe
  import bram_model_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  pipe_entry_t       in_entry,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  localparam pipe_entry_t FLUSH_ENTRY = '{rsp: RSP_NONE, data: {DATA_W_MAX{1'b1}}};

  pipe_entry_t       tail_s;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              unused_data_s;

  // The output register is the last stage, so only READ_LATENCY-1 stages
  // sit in front of it.
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign tail_s = in_entry;
    end else begin : g_stages
      pipe_entry_t stage_q [READ_LATENCY-1];
      pipe_entry_t stage_d [READ_LATENCY-1];

      // Shift the delay line by one slot per cycle
      always_comb begin
        stage_d[0] = in_entry;
        for (int k = 1; k < READ_LATENCY - 1; k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end

      // Delay-line storage, flushed asynchronously on reset
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < READ_LATENCY - 1; k++) begin
            stage_q[k] <= FLUSH_ENTRY;
          end
        end else begin
          for (int k = 0; k < READ_LATENCY - 1; k++) begin
            stage_q[k] <= stage_d[k];
          end
        end
      end

      assign tail_s = stage_q[READ_LATENCY-2];
    end
  endgenerate

  // Upper data bits are only meaningful for the widest configuration
  assign unused_data_s = ^tail_s.data;

  // Decode the tail entry into output pulses; rdata keeps its value when idle
  always_comb begin
    rvalid_d = (tail_s.rsp == RSP_DATA);
    err_d    = (tail_s.rsp == RSP_ERR);
    if (tail_s.rsp != RSP_NONE) begin
      rdata_d = tail_s.data[DATA_W-1:0];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output registers with reset values all-ones / 0 / 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= {DATA_W{1'b1}};
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: rtl/bram_model.sv
// bram_model
// Behavioural block-RAM with address decode, byte-enable writes and a
// configurable fixed response latency. Word i initially holds i + 1.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (memory keeps contents)
//   bus          : bram_model_if slave (en/we/addr/wdata/be in,
//                  rdata/rvalid/err out)
// Configuration macro BRAM_MODEL_WRITE_EN: when defined, in-range writes
// update memory; when undefined the block is read-only and every write
// request is answered with err.
module bram_model
  import bram_model_pkg::*;
#(
  parameter int          DATA_W       = DATA_W_DEFAULT,
  parameter int          DEPTH        = DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
  parameter int          READ_LATENCY = READ_LATENCY_DEFAULT
) (
  input logic         clk,
  input logic         reset_n,
  bram_model_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int ALIGN = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = DATA_W'(i + 32'sd1);
    end
    return m;
  endfunction

  // Contents are set at elaboration and never touched by reset
  mem_t mem_q = init_mem();

  logic [31:0]       offset_s;
  logic [31:0]       word_idx_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              wr_ok_s;
  pipe_entry_t       entry_s;

  // Address decode; the subtraction wraps below BASE_ADDR, hence the
  // explicit lower-bound test
  always_comb begin
    offset_s   = bus.addr - BASE_ADDR;
    word_idx_s = offset_s >> ALIGN;
    in_range_s = (bus.addr >= BASE_ADDR) &&
                 (offset_s[ALIGN-1:0] == {ALIGN{1'b0}}) &&
                 (word_idx_s < 32'(DEPTH));
    idx_s      = word_idx_s[IDX_W-1:0];
    rd_word_s  = mem_q[idx_s];
  end

`ifdef BRAM_MODEL_WRITE_EN
  logic [DATA_W-1:0] wr_word_d;

  assign wr_ok_s = in_range_s & bus.we;

  // Merge enabled write bytes over the current word
  always_comb begin
    wr_word_d = rd_word_s;
    for (int k = 0; k < BYTES; k++) begin
      if (bus.be[k]) begin
        wr_word_d[8*k +: 8] = bus.wdata[8*k +: 8];
      end else begin
        wr_word_d[8*k +: 8] = rd_word_s[8*k +: 8];
      end
    end
  end

  // Memory write port; reads in the same cycle see the old word
  always_ff @(posedge clk) begin
    if (reset_n && bus.en && wr_ok_s) begin
      mem_q[idx_s] <= wr_word_d;
    end
  end
`else
  logic unused_wr_s;

  assign wr_ok_s     = 1'b0;
  assign unused_wr_s = ^{bus.wdata, bus.be};
`endif

  // Classify the request into the response it owes
  always_comb begin
    entry_s.rsp  = RSP_NONE;
    entry_s.data = {DATA_W_MAX{1'b1}};
    if (bus.en) begin
      if (in_range_s && !bus.we) begin
        entry_s.rsp  = RSP_DATA;
        entry_s.data = DATA_W_MAX'(rd_word_s);
      end else if (wr_ok_s) begin
        entry_s.rsp  = RSP_NONE;
      end else begin
        entry_s.rsp  = RSP_ERR;
      end
    end else begin
      entry_s.rsp = RSP_NONE;
    end
  end

  bram_model_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_entry (entry_s),
    .rdata    (bus.rdata),
    .rvalid   (bus.rvalid),
    .err      (bus.err)
  );

endmodule

// File: tb/tb_bram_model.sv
// tb_bram_model
// Drives three bram_model instances (READ_LATENCY 1, 3 and 4) with the same
// request stream and checks every cycle against a cycle-indexed scoreboard.
// Honours BRAM_MODEL_WRITE_EN the same way the design does.
module tb_bram_model;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'hB000_0000;
  localparam int          NDUT   = 3;
  localparam int          LATS [NDUT] = '{1, 3, 4};
  localparam logic [1:0]  K_NONE = 2'd0;
  localparam logic [1:0]  K_DATA = 2'd1;
  localparam logic [1:0]  K_ERR  = 2'd2;
`ifdef BRAM_MODEL_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en_v = 1'b0;
  logic        we_v = 1'b0;
  logic [31:0] addr_v = 32'h0;
  logic [31:0] wdata_v = 32'h0;
  logic [3:0]  be_v = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_model_if #(.DATA_W(DATA_W)) bus1 ();
  bram_model_if #(.DATA_W(DATA_W)) bus3 ();
  bram_model_if #(.DATA_W(DATA_W)) bus4 ();

  assign bus1.en = en_v;  assign bus1.we = we_v;  assign bus1.addr = addr_v;
  assign bus1.wdata = wdata_v;  assign bus1.be = be_v;
  assign bus3.en = en_v;  assign bus3.we = we_v;  assign bus3.addr = addr_v;
  assign bus3.wdata = wdata_v;  assign bus3.be = be_v;
  assign bus4.en = en_v;  assign bus4.we = we_v;  assign bus4.addr = addr_v;
  assign bus4.wdata = wdata_v;  assign bus4.be = be_v;

  logic [31:0] o_rdata  [NDUT];
  logic        o_rvalid [NDUT];
  logic        o_err    [NDUT];

  assign o_rdata[0] = bus1.rdata;  assign o_rvalid[0] = bus1.rvalid;  assign o_err[0] = bus1.err;
  assign o_rdata[1] = bus3.rdata;  assign o_rvalid[1] = bus3.rvalid;  assign o_err[1] = bus3.err;
  assign o_rdata[2] = bus4.rdata;  assign o_rvalid[2] = bus4.rvalid;  assign o_err[2] = bus4.err;

  bram_model #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1))
    dut_l1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  bram_model #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(3))
    dut_l3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
  bram_model #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(4))
    dut_l4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  // ---------------- reference model ----------------
  bit          written [DEPTH];
  logic [31:0] mdl_mem [DEPTH];
  int          cyc = 0;
  bit          slot_v    [NDUT][16];
  int          slot_tgt  [NDUT][16];
  logic [1:0]  slot_kind [NDUT][16];
  logic [31:0] slot_data [NDUT][16];
  logic        exp_rvalid [NDUT] = '{default: 1'b0};
  logic        exp_err    [NDUT] = '{default: 1'b0};
  logic [31:0] exp_rdata  [NDUT] = '{default: 32'hFFFF_FFFF};

  function automatic logic [31:0] mem_rd(input int i);
    return written[i] ? mdl_mem[i] : 32'(i + 1);
  endfunction

  logic [31:0] req_off, req_idx, req_data, req_merged;
  logic        req_ok;
  logic [1:0]  req_kind;
  logic [1:0]  dlv_kind [NDUT];
  logic [31:0] dlv_data [NDUT];

  // What the request currently on the bus is owed
  always_comb begin
    req_off  = addr_v - BASE;
    req_idx  = req_off / 4;
    req_ok   = (addr_v >= BASE) && (req_off % 4 == 0) && (req_idx < DEPTH);
    req_kind = K_NONE;
    req_data = 32'hFFFF_FFFF;
    req_merged = req_ok ? mem_rd(int'(req_idx)) : 32'h0;
    for (int k = 0; k < 4; k++)
      if (be_v[k]) req_merged[8*k +: 8] = wdata_v[8*k +: 8];
    if (en_v) begin
      if (req_ok && !we_v) begin
        req_kind = K_DATA;
        req_data = mem_rd(int'(req_idx));
      end else if (req_ok && we_v && WR_EN) req_kind = K_NONE;
      else req_kind = K_ERR;
    end
  end

  // Which response becomes visible at the coming edge, per latency
  always_comb begin
    for (int d = 0; d < NDUT; d++) begin
      dlv_kind[d] = K_NONE;
      dlv_data[d] = 32'hFFFF_FFFF;
      if (LATS[d] == 1) begin
        dlv_kind[d] = req_kind;
        dlv_data[d] = req_data;
      end else if (slot_v[d][(cyc + 1) % 16] && slot_tgt[d][(cyc + 1) % 16] == cyc + 1) begin
        dlv_kind[d] = slot_kind[d][(cyc + 1) % 16];
        dlv_data[d] = slot_data[d][(cyc + 1) % 16];
      end
    end
  end

  // Scoreboard update: requests keyed by the edge their response is due
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int s = 0; s < 16; s++) slot_v[d][s] <= 1'b0;
        exp_rvalid[d] <= 1'b0;
        exp_err[d]    <= 1'b0;
        exp_rdata[d]  <= 32'hFFFF_FFFF;
      end
    end else begin
      cyc <= cyc + 1;
      if (en_v && req_ok && we_v && WR_EN) begin
        written[req_idx[7:0]] <= 1'b1;
        mdl_mem[req_idx[7:0]] <= req_merged;
      end
      for (int d = 0; d < NDUT; d++) begin
        slot_v[d][(cyc + LATS[d]) % 16]    <= 1'b1;
        slot_tgt[d][(cyc + LATS[d]) % 16]  <= cyc + LATS[d];
        slot_kind[d][(cyc + LATS[d]) % 16] <= req_kind;
        slot_data[d][(cyc + LATS[d]) % 16] <= req_data;
        exp_rvalid[d] <= (dlv_kind[d] == K_DATA);
        exp_err[d]    <= (dlv_kind[d] == K_ERR);
        if (dlv_kind[d] != K_NONE) exp_rdata[d] <= dlv_data[d];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("lat%0d_rvalid", LATS[d]), 64'(o_rvalid[d]), 64'(exp_rvalid[d]));
      chk($sformatf("lat%0d_err", LATS[d]),    64'(o_err[d]),    64'(exp_err[d]));
      chk($sformatf("lat%0d_rdata", LATS[d]),  64'(o_rdata[d]),  64'(exp_rdata[d]));
    end
  end

  task automatic drv(input logic e, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b);
    en_v = e; we_v = w; addr_v = a; wdata_v = wd; be_v = b;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Requests held during reset must be ignored
    drv(1'b1, 1'b0, BASE, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_rdata", 64'(o_rdata[0]), 64'hFFFF_FFFF);
    chk("rst_rvalid", 64'(o_rvalid[2]), 64'h0);
    reset_n = 1'b1;
    idle();
    @(negedge clk);

    // Consecutive reads of words 0, 1, 2
    drv(1'b1, 1'b0, BASE + 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("l1_rd_w0", 64'(o_rdata[0]), 64'h1);
    drv(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    chk("l1_rd_w1", 64'(o_rdata[0]), 64'h2);
    drv(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    chk("l1_rd_w2", 64'(o_rdata[0]), 64'h3);
    chk("l1_rd_w2_v", 64'(o_rvalid[0]), 64'h1);
    chk("l3_rd_w0", 64'(o_rdata[1]), 64'h1);
    chk("l3_rd_w0_v", 64'(o_rvalid[1]), 64'h1);
    idle();
    @(negedge clk);
    chk("l3_rd_w1", 64'(o_rdata[1]), 64'h2);
    chk("l4_rd_w0", 64'(o_rdata[2]), 64'h1);
    @(negedge clk);
    chk("l3_rd_w2", 64'(o_rdata[1]), 64'h3);
    chk("l4_rd_w1", 64'(o_rdata[2]), 64'h2);
    @(negedge clk);
    chk("l4_rd_w2", 64'(o_rdata[2]), 64'h3);
    chk("l3_pulse_end", 64'(o_rvalid[1]), 64'h0);

    // Rejected addresses: misaligned, one past the end, below base
    drv(1'b1, 1'b0, BASE + 32'h2, 32'h0, 4'h0);
    @(negedge clk);
    chk("oor_misal_err", 64'(o_err[0]), 64'h1);
    chk("oor_misal_rvalid", 64'(o_rvalid[0]), 64'h0);
    chk("oor_misal_rdata", 64'(o_rdata[0]), 64'hFFFF_FFFF);
    drv(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
    @(negedge clk);
    chk("oor_end_err", 64'(o_err[0]), 64'h1);
    chk("oor_end_rvalid", 64'(o_rvalid[0]), 64'h0);
    drv(1'b1, 1'b0, BASE - 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    chk("oor_below_err", 64'(o_err[0]), 64'h1);
    chk("oor_below_rdata", 64'(o_rdata[0]), 64'hFFFF_FFFF);
    idle();
    @(negedge clk);
    chk("err_pulse_end", 64'(o_err[0]), 64'h0);

`ifdef BRAM_MODEL_WRITE_EN
    drv(1'b1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    chk("wr_no_err", 64'(o_err[0]), 64'h0);
    chk("wr_no_rvalid", 64'(o_rvalid[0]), 64'h0);
    drv(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("wr_be_rdata", 64'(o_rdata[0]), 64'h0000_BEEF);
    chk("wr_be_rvalid", 64'(o_rvalid[0]), 64'h1);
`else
    drv(1'b1, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("ro_wr_err", 64'(o_err[0]), 64'h1);
    drv(1'b1, 1'b0, BASE, 32'h0, 4'h0);
    @(negedge clk);
    chk("ro_rd_rdata", 64'(o_rdata[0]), 64'h1);
    chk("ro_rd_rvalid", 64'(o_rvalid[0]), 64'h1);
`endif
    idle();
    @(negedge clk);

    // Reset dropped while a latency-4 read is in flight
    drv(1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rdata", 64'(o_rdata[2]), 64'hFFFF_FFFF);
    chk("midrst_rvalid", 64'(o_rvalid[2]), 64'h0);
    chk("midrst_err", 64'(o_err[2]), 64'h0);
    chk("midrst_l1_rdata", 64'(o_rdata[0]), 64'hFFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        int unsigned mode;
        logic [31:0] idx;
        logic [31:0] a;
        mode = $urandom_range(0, 9);
        idx  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15))
                                           : 32'($urandom_range(0, DEPTH - 1));
        if (mode <= 6)      a = BASE + 4 * idx;
        else if (mode == 7) a = BASE + 4 * idx + 32'($urandom_range(1, 3));
        else if (mode == 8) a = BASE + 32'(4 * DEPTH) + 4 * 32'($urandom_range(0, 64));
        else                a = BASE - 4 * 32'($urandom_range(1, 64));
        drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            $urandom, 4'($urandom_range(0, 15)));
        @(negedge clk);
      end
    end

    idle();
    repeat (6) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
